segmented_adder: RTL

SEGMENTED_ADDER -- requirements
Module: segmented_adder

---
 rtl/segmented_adder_if.sv | 34 +++
 rtl/segmented_adder.sv | 132 +++++++++++++
 2 files changed

// File: rtl/segmented_adder_if.sv
`default_nettype none
// ============================================================================
//  Module   : segmented_adder_if
//  Brief    : Request/response bundle for the segmented adder.
//  Revision : 1.0
// ============================================================================
interface segmented_adder_if #(
    parameter int N = 16
);
    logic         in_valid;
    logic         in_ready;
    logic [N-1:0] a;
    logic [N-1:0] b;
    logic         ci;
    logic         sub;
    logic         acc;
    logic         acc_clr;
    logic         out_valid;
    logic         out_ready;
    logic [N-1:0] s;
    logic         co;
    logic         ovf;

    modport slave (
        input  in_valid, a, b, ci, sub, acc, acc_clr, out_ready,
        output in_ready, out_valid, s, co, ovf
    );

    modport master (
        output in_valid, a, b, ci, sub, acc, acc_clr, out_ready,
        input  in_ready, out_valid, s, co, ovf
    );
endinterface
`default_nettype wire

// File: rtl/segmented_adder.sv
`default_nettype none
// ============================================================================
//  Module   : segmented_adder
//  Brief    : N-bit add/sub processed W bits per clock, with accumulator.
//  Revision : 1.0
// ============================================================================
module segmented_adder #(
    parameter int N = 16,
    parameter int W = 4
) (
    input  logic               clk,
    input  logic               rst,
    segmented_adder_if.slave   bus
);
    localparam int K  = N / W;
    localparam int CW = (K > 1) ? $clog2(K) : 1;
    localparam logic [CW-1:0] c_last = CW'(K - 1);

    generate
        if ((W < 1) || (N % W != 0)) begin : g_bad_width
            $error("segmented_adder: N must be a non-zero multiple of W");
        end
    endgenerate

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t        r_state;
    logic [N-1:0]  r_a;
    logic [N-1:0]  r_b;
    logic [N-1:0]  r_s;
    logic [N-1:0]  r_acc;
    logic          r_carry;
    logic          r_co;
    logic          r_ovf;
    logic          r_use_acc;
    logic [CW-1:0] r_cnt;

    logic [N-1:0]  w_b_sel;
    logic [N-1:0]  w_b_eff;
    logic [W:0]    w_seg;
    logic [N-1:0]  w_s_next;
    logic [N-1:0]  w_a_shift;
    logic [N-1:0]  w_b_shift;
    logic          w_ovf_last;

    // acc_clr coincident with an accumulate accept must feed a zero operand.
    assign w_b_sel = bus.acc ? (bus.acc_clr ? '0 : r_acc) : bus.b;
    assign w_b_eff = bus.sub ? ~w_b_sel : w_b_sel;

    // Operands shift down so the active segment is always the low W bits.
    assign w_seg = {1'b0, r_a[W-1:0]} + {1'b0, r_b[W-1:0]} + {{W{1'b0}}, r_carry};

    generate
        if (K == 1) begin : g_single
            assign w_s_next  = w_seg[W-1:0];
            assign w_a_shift = '0;
            assign w_b_shift = '0;
        end else begin : g_multi
            assign w_s_next  = {w_seg[W-1:0], r_s[N-1:W]};
            assign w_a_shift = {{W{1'b0}}, r_a[N-1:W]};
            assign w_b_shift = {{W{1'b0}}, r_b[N-1:W]};
        end
    endgenerate

    // Carry into the MSB is a^b^s at that bit; overflow compares it with carry out.
    assign w_ovf_last = r_a[W-1] ^ r_b[W-1] ^ w_seg[W-1] ^ w_seg[W];

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_a       <= '0;
            r_b       <= '0;
            r_s       <= '0;
            r_acc     <= '0;
            r_carry   <= 1'b0;
            r_co      <= 1'b0;
            r_ovf     <= 1'b0;
            r_use_acc <= 1'b0;
            r_cnt     <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (bus.acc_clr) begin
                        r_acc <= '0;
                    end
                    if (bus.in_valid) begin
                        r_a       <= bus.a;
                        r_b       <= w_b_eff;
                        r_carry   <= bus.sub ^ bus.ci;
                        r_use_acc <= bus.acc;
                        r_cnt     <= '0;
                        r_state   <= S_RUN;
                    end
                end
                S_RUN: begin
                    r_a     <= w_a_shift;
                    r_b     <= w_b_shift;
                    r_s     <= w_s_next;
                    r_carry <= w_seg[W];
                    r_cnt   <= r_cnt + 1'b1;
                    if (r_cnt == c_last) begin
                        r_co  <= w_seg[W];
                        r_ovf <= w_ovf_last;
                        if (r_use_acc) begin
                            r_acc <= w_s_next;
                        end
                        r_state <= S_DONE;
                    end
                end
                S_DONE: begin
                    if (bus.out_ready) begin
                        r_state <= S_IDLE;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.in_ready  = (r_state == S_IDLE);
    assign bus.out_valid = (r_state == S_DONE);
    assign bus.s         = r_s;
    assign bus.co        = r_co;
    assign bus.ovf       = r_ovf;
endmodule
`default_nettype wire
